acl_rule_loader: RTL
====================

# acl_rule_loader

Programming-side counterpart of the ACL match engine: accepts 5-tuple drop rules over a valid/ready stream from the AXI-Lite register block and drives the engine's write interface (acl_write_en/addr/data, acl_clear). For each rule it computes the engine's CRC16 bucket index with a multi-cycle iterative CRC, then issues exactly one write. It also sequences table clears and keeps rule/reject statistics. It sits between the control-plane register file and the ACL match engine config port.

## Interface
- ADDR_WIDTH, 12, bucket index width; equals CRC bits used, taken as crc[ADDR_WIDTH-1:0]
- DATA_WIDTH, 104, 5-tuple width (32+16+32+16+8)
- BITS_PER_CYCLE, 8, tuple bits folded into CRC per cycle; must divide DATA_WIDTH (elaboration error otherwise)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rule_valid  in  1  rule_tuple valid
- rule_ready  out  1  loader can accept a rule
- rule_tuple  in  DATA_WIDTH  rule 5-tuple
- clear_req  in  1  single-cycle clear request
- acl_write_en  out  1  one-cycle write strobe to engine
- acl_write_addr  out  ADDR_WIDTH  bucket index
- acl_write_data  out  DATA_WIDTH  tuple written
- acl_clear  out  1  one-cycle clear strobe to engine
- busy  out  1  state != IDLE or clear pending
- rule_count  out  32  rules written since last clear/reset
- reject_count  out  32  rules rejected (all-zero tuple)

## Operation
- States: IDLE, HASH, WRITE, CLEAR.
- rule_ready = (state==IDLE) && !clear_pending && !clear_req (clear has priority; combinational on clear_req only, never on rule_valid).
- Handshake = rule_valid && rule_ready. On handshake: if rule_tuple == 0 → reject_count++, stay IDLE, no write (zero is the engine's empty marker). Else latch tuple, crc <= 16'h0000, beat <= 0, go HASH.
- HASH: N = DATA_WIDTH/BITS_PER_CYCLE cycles. Each cycle fold next BITS_PER_CYCLE tuple bits, MSB first, bit-serial CRC16-CCITT: poly 0x1021, init 0x0000, no reflection, no final XOR (bit-exact with engine hash). After beat N-1 → WRITE.
- WRITE: acl_write_en=1 one cycle, addr=crc[ADDR_WIDTH-1:0], data=latched tuple; rule_count++ (saturating at 32'hFFFFFFFF). Next: CLEAR if clear_pending else IDLE.
- clear_req in IDLE → CLEAR next cycle. clear_req in HASH/WRITE → clear_pending=1; in-flight rule completes its write, then CLEAR. clear_req in CLEAR or while pending → merged (one clear).
- CLEAR: acl_clear=1 one cycle, rule_count <= 0, clear_pending <= 0 → IDLE. reject_count not cleared.
- acl_write_en and acl_clear never asserted in the same cycle.
- reject_count saturates at 32'hFFFFFFFF.

## Timing
- All outputs registered or decoded from registered state; no combinational path input→acl_* outputs.
- Reset values: rule_ready=1 (IDLE), acl_write_en=0, acl_write_addr=0, acl_write_data=0, acl_clear=0, busy=0, rule_count=0, reject_count=0, clear_pending=0.
- Handshake at cycle 0 → HASH cycles 1..N → acl_write_en high cycle N+1 → rule_ready high cycle N+2. Default N=13: write at cycle 14, throughput one rule per 15 cycles.
- Zero-tuple reject: reject_count updates cycle 1, rule_ready stays high.
- clear_req at cycle 0 in IDLE → acl_clear high cycle 1 → rule_ready high cycle 2.
- acl_write_addr/data hold last written value outside WRITE.
- Reset mid-HASH/WRITE/CLEAR: immediate return to IDLE, partial rule discarded, no write or clear issued, pending clear dropped.

## Structure
- Shared package acl_pkg: ACL_ADDR_WIDTH=12, ACL_TUPLE_WIDTH=104, CRC16_POLY=16'h1021, CRC16_INIT=16'h0000, loader state enum; match engine migrates to the same constants.
- One sub-module: acl_crc16_step — combinational, folds BITS_PER_CYCLE bits into a 16-bit CRC; reused by engine-side hash and the bench reference model.

## Test plan
- rule_tuple=104'h1 → acl_write_en at cycle 14, addr=12'h021, data=104'h1, rule_count=1.
- rule_tuple=104'h2 → addr=12'h042; back-to-back rule_valid held high → second handshake exactly 15 cycles after first.
- rule_tuple=0 → no acl_write_en, reject_count=1, rule_ready never drops.
- clear_req at cycle 5 of a HASH → write at cycle 14, acl_clear at cycle 15, rule_count=0 at cycle 16; rule_valid and clear_req together in IDLE → rule not accepted, clear issued.
- rst_n asserted during HASH cycle 7 → all outputs at reset values, no write afterwards; 200 random nonzero tuples → every addr matches reference CRC model, no write/clear overlap.

Source files
------------

// File: rtl/acl_pkg.sv
// Shared ACL constants, loader state encoding and CRC16 bit step.
package acl_pkg;

   localparam int unsigned ACL_ADDR_WIDTH  = 12;
   localparam int unsigned ACL_TUPLE_WIDTH = 104;
   localparam int unsigned CRC16_WIDTH     = 16;

   localparam logic [CRC16_WIDTH-1:0] CRC16_POLY = 16'h1021;
   localparam logic [CRC16_WIDTH-1:0] CRC16_INIT = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HASH  = 2'd1,
      ST_WRITE = 2'd2,
      ST_CLEAR = 2'd3
   } loader_state_t;

   // 5-tuple layout as stored by the match engine, MSB first
   typedef struct packed {
      logic [31:0] src_ip;
      logic [15:0] src_port;
      logic [31:0] dst_ip;
      logic [15:0] dst_port;
      logic [7:0]  proto;
   } acl_tuple_t;

   // One bit of MSB-first CRC16-CCITT (no reflection)
   function automatic logic [CRC16_WIDTH-1:0] crc16_bit(input logic [CRC16_WIDTH-1:0] crc,
                                                         input logic din);
      logic [CRC16_WIDTH-1:0] shifted;
      shifted = {crc[CRC16_WIDTH-2:0], 1'b0};
      return (crc[CRC16_WIDTH-1] ^ din) ? (shifted ^ CRC16_POLY) : shifted;
   endfunction

endpackage

// File: rtl/acl_crc16_step.sv
// Folds BITS input bits (MSB first) into a running CRC16-CCITT value.
module acl_crc16_step
   import acl_pkg::*;
#(
   parameter int unsigned BITS = 8
) (
   input  logic [CRC16_WIDTH-1:0] i_crc,
   input  logic [BITS-1:0]        i_data,
   output logic [CRC16_WIDTH-1:0] o_crc_c
);

   logic [CRC16_WIDTH-1:0] w_crc;
   logic [BITS-1:0]        w_bits;

   // Bit-serial fold, unrolled across the slice
   always_comb begin
      w_crc  = i_crc;
      w_bits = i_data;
      for (int unsigned i = 0; i < BITS; i++) begin
         w_crc  = crc16_bit(w_crc, w_bits[BITS-1]);
         w_bits = w_bits << 1;
      end
   end

   assign o_crc_c = w_crc;

endmodule

// File: rtl/acl_rule_loader.sv
// Accepts ACL drop rules, hashes each into a bucket index with an iterative
// CRC16 and issues one engine write per rule; also sequences table clears.
module acl_rule_loader
   import acl_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = ACL_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH     = ACL_TUPLE_WIDTH,
   parameter int unsigned BITS_PER_CYCLE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rule_valid,
   output logic                  rule_ready,
   input  logic [DATA_WIDTH-1:0] rule_tuple,
   input  logic                  clear_req,
   output logic                  acl_write_en,
   output logic [ADDR_WIDTH-1:0] acl_write_addr,
   output logic [DATA_WIDTH-1:0] acl_write_data,
   output logic                  acl_clear,
   output logic                  busy,
   output logic [31:0]           rule_count,
   output logic [31:0]           reject_count
);

   localparam int unsigned BEATS  = DATA_WIDTH / BITS_PER_CYCLE;
   localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   // Reject configurations the iterative hash cannot express
   generate
      if ((BITS_PER_CYCLE == 0) || ((DATA_WIDTH % BITS_PER_CYCLE) != 0) ||
          (ADDR_WIDTH > CRC16_WIDTH)) begin : g_bad_cfg
         $error("acl_rule_loader: BITS_PER_CYCLE must divide DATA_WIDTH and ADDR_WIDTH <= 16");
      end
   endgenerate

   loader_state_t          r_state;
   logic [DATA_WIDTH-1:0]  r_tuple;
   logic [DATA_WIDTH-1:0]  r_shift;
   logic [CRC16_WIDTH-1:0] r_crc;
   logic [BEAT_W-1:0]      r_beat;
   logic                   r_clear_pending;
   logic                   r_write_en;
   logic [ADDR_WIDTH-1:0]  r_write_addr;
   logic [DATA_WIDTH-1:0]  r_write_data;
   logic                   r_clear;
   logic [31:0]            r_rule_count;
   logic [31:0]            r_reject_count;

   logic [CRC16_WIDTH-1:0] w_crc_next;
   logic                   w_accept;

   acl_crc16_step #(
      .BITS (BITS_PER_CYCLE)
   ) u_crc_step (
      .i_crc   (r_crc),
      .i_data  (r_shift[DATA_WIDTH-1 -: BITS_PER_CYCLE]),
      .o_crc_c (w_crc_next)
   );

   // Clear requests take priority over rule acceptance
   assign rule_ready = (r_state == ST_IDLE) && !r_clear_pending && !clear_req;
   assign w_accept   = rule_valid && rule_ready;

   // Loader FSM, hash datapath, engine strobes and statistics
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_tuple         <= '0;
         r_shift         <= '0;
         r_crc           <= CRC16_INIT;
         r_beat          <= '0;
         r_clear_pending <= 1'b0;
         r_write_en      <= 1'b0;
         r_write_addr    <= '0;
         r_write_data    <= '0;
         r_clear         <= 1'b0;
         r_rule_count    <= '0;
         r_reject_count  <= '0;
      end else begin
         r_write_en <= 1'b0;
         r_clear    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (clear_req) begin
                  r_state <= ST_CLEAR;
                  r_clear <= 1'b1;
               end else if (w_accept) begin
                  if (rule_tuple == '0) begin
                     // all-zero is the engine's empty-slot marker
                     if (r_reject_count != 32'hFFFF_FFFF)
                        r_reject_count <= r_reject_count + 32'd1;
                  end else begin
                     r_tuple <= rule_tuple;
                     r_shift <= rule_tuple;
                     r_crc   <= CRC16_INIT;
                     r_beat  <= '0;
                     r_state <= ST_HASH;
                  end
               end
            end
            ST_HASH: begin
               if (clear_req)
                  r_clear_pending <= 1'b1;
               r_crc   <= w_crc_next;
               r_shift <= r_shift << BITS_PER_CYCLE;
               r_beat  <= r_beat + BEAT_W'(1);
               if (r_beat == BEAT_W'(BEATS - 1)) begin
                  r_state      <= ST_WRITE;
                  r_write_en   <= 1'b1;
                  r_write_addr <= w_crc_next[ADDR_WIDTH-1:0];
                  r_write_data <= r_tuple;
                  if (r_rule_count != 32'hFFFF_FFFF)
                     r_rule_count <= r_rule_count + 32'd1;
               end
            end
            ST_WRITE: begin
               if (r_clear_pending || clear_req) begin
                  r_clear_pending <= 1'b1;
                  r_state         <= ST_CLEAR;
                  r_clear         <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_CLEAR: begin
               // any clear_req seen here merges into this clear
               r_rule_count    <= '0;
               r_clear_pending <= 1'b0;
               r_state         <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign acl_write_en   = r_write_en;
   assign acl_write_addr = r_write_addr;
   assign acl_write_data = r_write_data;
   assign acl_clear      = r_clear;
   assign busy           = (r_state != ST_IDLE) || r_clear_pending;
   assign rule_count     = r_rule_count;
   assign reject_count   = r_reject_count;

endmodule
